// File: rtl/rgb_yuv_pkg.sv
// Shared constants and helpers for the RGB to BT.601 limited-range 4:2:2 packer.
package rgb_yuv_pkg;

    localparam int PIXEL_WIDTH  = 16;
    localparam int PIXEL_SHIFT  = 2;
    localparam int INPUT_WIDTH  = 192;
    localparam int OUTPUT_WIDTH = 64;
    localparam int NUM_PIXELS   = 4;
    localparam int PIXEL_BITS   = 3 * PIXEL_WIDTH;
    localparam int PROD_W       = 18;
    localparam int SUM_W        = 19;

    // Component positions inside one 48-bit pixel
    localparam int R_OFS = 32;
    localparam int G_OFS = 16;
    localparam int B_OFS = 0;

    localparam logic signed [PROD_W-1:0] COEF_YR = 18'sd66;
    localparam logic signed [PROD_W-1:0] COEF_YG = 18'sd129;
    localparam logic signed [PROD_W-1:0] COEF_YB = 18'sd25;
    localparam logic signed [PROD_W-1:0] COEF_UR = -18'sd38;
    localparam logic signed [PROD_W-1:0] COEF_UG = -18'sd74;
    localparam logic signed [PROD_W-1:0] COEF_UB = 18'sd112;
    localparam logic signed [PROD_W-1:0] COEF_VR = 18'sd112;
    localparam logic signed [PROD_W-1:0] COEF_VG = -18'sd94;
    localparam logic signed [PROD_W-1:0] COEF_VB = -18'sd18;

    localparam logic signed [SUM_W-1:0] ROUND    = 19'sd128;
    localparam logic signed [SUM_W-1:0] Y_OFFSET = 19'sd16;
    localparam logic signed [SUM_W-1:0] C_OFFSET = 19'sd128;

    function automatic logic [7:0] comp_to_u8(input logic [PIXEL_WIDTH-1:0] c);
        logic [PIXEL_WIDTH-1:0] s;
        s = c >> PIXEL_SHIFT;
        if (s > 16'd255) begin
            return 8'hFF;
        end else begin
            return 8'(s);
        end
    endfunction

    function automatic logic [7:0] clamp_u8(input logic signed [SUM_W-1:0] v);
        if (v < 19'sd0) begin
            return 8'h00;
        end else if (v > 19'sd255) begin
            return 8'hFF;
        end else begin
            return 8'(v);
        end
    endfunction

endpackage

// File: rtl/rgb_yuv_pixel.sv
// Two-stage single-pixel RGB to YCbCr converter: weighted sums, then round/offset/clamp.
module rgb_yuv_pixel
    import rgb_yuv_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [PIXEL_BITS-1:0] pixel_i,
    output logic [7:0]            y_o,
    output logic [7:0]            u_o,
    output logic [7:0]            v_o
);

    logic signed [PROD_W-1:0] r_s, g_s, b_s;
    logic signed [PROD_W-1:0] y_prod_s, u_prod_s, v_prod_s;
    logic signed [PROD_W-1:0] y_prod_r, u_prod_r, v_prod_r;
    logic signed [SUM_W-1:0]  y_sum_s, u_sum_s, v_sum_s;

    // Scale each component to 8 bits and form the Q8 weighted sums
    always_comb begin
        r_s      = PROD_W'(comp_to_u8(pixel_i[R_OFS +: PIXEL_WIDTH]));
        g_s      = PROD_W'(comp_to_u8(pixel_i[G_OFS +: PIXEL_WIDTH]));
        b_s      = PROD_W'(comp_to_u8(pixel_i[B_OFS +: PIXEL_WIDTH]));
        y_prod_s = COEF_YR * r_s + COEF_YG * g_s + COEF_YB * b_s;
        u_prod_s = COEF_UR * r_s + COEF_UG * g_s + COEF_UB * b_s;
        v_prod_s = COEF_VR * r_s + COEF_VG * g_s + COEF_VB * b_s;
    end

    // Stage 1 register: weighted sums
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            y_prod_r <= 18'sd0;
            u_prod_r <= 18'sd0;
            v_prod_r <= 18'sd0;
        end else begin
            y_prod_r <= y_prod_s;
            u_prod_r <= u_prod_s;
            v_prod_r <= v_prod_s;
        end
    end

    // Round, arithmetic shift back from Q8 and add the limited-range offsets
    always_comb begin
        y_sum_s = (($signed({y_prod_r[PROD_W-1], y_prod_r}) + ROUND) >>> 8) + Y_OFFSET;
        u_sum_s = (($signed({u_prod_r[PROD_W-1], u_prod_r}) + ROUND) >>> 8) + C_OFFSET;
        v_sum_s = (($signed({v_prod_r[PROD_W-1], v_prod_r}) + ROUND) >>> 8) + C_OFFSET;
    end

    // Stage 2 register: clamped 8-bit Y, U, V
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            y_o <= 8'h00;
            u_o <= 8'h00;
            v_o <= 8'h00;
        end else begin
            y_o <= clamp_u8(y_sum_s);
            u_o <= clamp_u8(u_sum_s);
            v_o <= clamp_u8(v_sum_s);
        end
    end

endmodule

// File: rtl/rgb_yuv422_packer.sv
// Four-pixel RGB to YUYV 4:2:2 packer, fixed 3-cycle latency, no backpressure.
// Optional line word statistics enabled by defining RGB2YUV_LINE_STATS_EN.
module rgb_yuv422_packer
    import rgb_yuv_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    line_valid_i,
    input  logic                    data_valid_i,
    input  logic [INPUT_WIDTH-1:0]  data_i,
    output logic                    output_valid_o,
    output logic                    line_valid_o,
    output logic [OUTPUT_WIDTH-1:0] output_o
`ifdef RGB2YUV_LINE_STATS_EN
    ,
    output logic [15:0]             line_words_o,
    output logic                    line_stats_valid_o
`endif
);

    logic [7:0] y_s [NUM_PIXELS];
    logic [7:0] u_s [NUM_PIXELS];
    logic [7:0] v_s [NUM_PIXELS];
    logic [1:0] valid_pipe_r;
    logic [1:0] line_pipe_r;
    logic [7:0] u01_s, v01_s, u23_s, v23_s;
    logic [OUTPUT_WIDTH-1:0] word_s;

    // Pixel 0 occupies the most significant 48 bits
    for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
        rgb_yuv_pixel u_pix (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .pixel_i (data_i[(NUM_PIXELS-1-gi)*PIXEL_BITS +: PIXEL_BITS]),
            .y_o     (y_s[gi]),
            .u_o     (u_s[gi]),
            .v_o     (v_s[gi])
        );
    end

    // Valid and line flags travel alongside the two converter stages
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_pipe_r <= 2'b00;
            line_pipe_r  <= 2'b00;
        end else begin
            valid_pipe_r <= {valid_pipe_r[0], data_valid_i};
            line_pipe_r  <= {line_pipe_r[0], line_valid_i};
        end
    end

    // Truncating chroma pair averages and YUYV packing
    always_comb begin
        u01_s  = 8'((9'(u_s[0]) + 9'(u_s[1])) >> 1);
        v01_s  = 8'((9'(v_s[0]) + 9'(v_s[1])) >> 1);
        u23_s  = 8'((9'(u_s[2]) + 9'(u_s[3])) >> 1);
        v23_s  = 8'((9'(v_s[2]) + 9'(v_s[3])) >> 1);
        word_s = {y_s[0], u01_s, y_s[1], v01_s, y_s[2], u23_s, y_s[3], v23_s};
    end

    // Stage 3 register: output word is held while no valid word arrives
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            output_valid_o <= 1'b0;
            line_valid_o   <= 1'b0;
            output_o       <= 64'd0;
        end else begin
            output_valid_o <= valid_pipe_r[1];
            line_valid_o   <= line_pipe_r[1];
            if (valid_pipe_r[1]) begin
                output_o <= word_s;
            end else begin
                output_o <= output_o;
            end
        end
    end

`ifdef RGB2YUV_LINE_STATS_EN
    logic [15:0] word_cnt_r;
    logic        line_prev_r;
    logic        line_end_s;

    assign line_end_s = line_prev_r & ~line_valid_o;

    // Count emitted words per line, report and clear on the line's falling edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            word_cnt_r         <= 16'd0;
            line_prev_r        <= 1'b0;
            line_words_o       <= 16'd0;
            line_stats_valid_o <= 1'b0;
        end else begin
            line_prev_r <= line_valid_o;
            if (line_end_s) begin
                line_words_o       <= word_cnt_r;
                line_stats_valid_o <= 1'b1;
                word_cnt_r         <= 16'd0;
            end else begin
                line_words_o       <= line_words_o;
                line_stats_valid_o <= 1'b0;
                if (output_valid_o && line_valid_o && (word_cnt_r != 16'hFFFF)) begin
                    word_cnt_r <= word_cnt_r + 16'd1;
                end else begin
                    word_cnt_r <= word_cnt_r;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rgb_yuv422_packer.sv
// Scoreboard bench for rgb_yuv422_packer with a behavioural YUV reference model.
module tb_rgb_yuv422_packer;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         line_valid_i;
    logic         data_valid_i;
    logic [191:0] data_i;
    logic         output_valid_o;
    logic         line_valid_o;
    logic [63:0]  output_o;
`ifdef RGB2YUV_LINE_STATS_EN
    logic [15:0]  line_words_o;
    logic         line_stats_valid_o;
`endif

    rgb_yuv422_packer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .line_valid_i   (line_valid_i),
        .data_valid_i   (data_valid_i),
        .data_i         (data_i),
        .output_valid_o (output_valid_o),
        .line_valid_o   (line_valid_o),
        .output_o       (output_o)
`ifdef RGB2YUV_LINE_STATS_EN
        ,
        .line_words_o       (line_words_o),
        .line_stats_valid_o (line_stats_valid_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] word;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] last_word = 64'd0;
    bit          lv_d0, lv_d1, lv_d2;

    always @(posedge clk_i) cyc <= cyc + 1;

    // line_valid_i delayed three clocks, cleared by reset
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lv_d0 <= 1'b0; lv_d1 <= 1'b0; lv_d2 <= 1'b0;
        end else begin
            lv_d0 <= line_valid_i; lv_d1 <= lv_d0; lv_d2 <= lv_d1;
        end
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int clamp255(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference: BT.601 limited range per pixel, then 4:2:2 truncating chroma average
    function automatic logic [63:0] model(input logic [191:0] d);
        int y[4], u[4], v[4];
        int r, g, b;
        logic [15:0] c;
        logic [7:0] y8[4];
        logic [7:0] u01, v01, u23, v23;
        for (int i = 0; i < 4; i++) begin
            c = d[191 - 48*i -: 16];     r = int'(c) >> 2; if (r > 255) r = 255;
            c = d[175 - 48*i -: 16];     g = int'(c) >> 2; if (g > 255) g = 255;
            c = d[159 - 48*i -: 16];     b = int'(c) >> 2; if (b > 255) b = 255;
            y[i] = clamp255(((66*r + 129*g + 25*b + 128) >>> 8) + 16);
            u[i] = clamp255(((-38*r - 74*g + 112*b + 128) >>> 8) + 128);
            v[i] = clamp255(((112*r - 94*g - 18*b + 128) >>> 8) + 128);
            y8[i] = 8'(y[i]);
        end
        u01 = 8'((u[0] + u[1]) / 2);
        v01 = 8'((v[0] + v[1]) / 2);
        u23 = 8'((u[2] + u[3]) / 2);
        v23 = 8'((v[2] + v[3]) / 2);
        return {y8[0], u01, y8[1], v01, y8[2], u23, y8[3], v23};
    endfunction

    function automatic logic [47:0] px(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [15:0] rand_comp();
        if ($urandom_range(0, 3) == 0) return 16'($urandom_range(0, 65535));
        return 16'($urandom_range(0, 1023));
    endfunction

    task automatic drive(input logic dv, input logic lv, input logic [191:0] d,
                         input logic use_const, input logic [63:0] const_w);
        exp_t e;
        @(posedge clk_i);
        #1;
        data_valid_i = dv;
        line_valid_i = lv;
        data_i       = d;
        if (dv) begin
            e.word = use_const ? const_w : model(d);
            e.cyc  = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drive_rand(input logic dv, input logic lv);
        logic [191:0] d;
        for (int p = 0; p < 4; p++) d[191 - 48*p -: 48] = px(rand_comp(), rand_comp(), rand_comp());
        drive(dv, lv, d, 1'b0, 64'd0);
    endtask

    // Monitor: pops the scoreboard on each valid word, checks hold and line delay
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!reset_i) begin
            check_int("line_valid_delay", int'(line_valid_o), int'(lv_d2));
            if (output_valid_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h with nothing pending (t=%0t)", output_o, $time);
                end else begin
                    e = sb.pop_front();
                    check64("word", output_o, e.word);
                    check_int("latency", cyc - e.cyc, 3);
                    last_word = e.word;
                end
            end else begin
                check64("hold", output_o, last_word);
            end
        end
    end

`ifdef RGB2YUV_LINE_STATS_EN
    int tb_cnt = 0;
    int pending = 0;
    bit prev_lv = 1'b0;
    // Stats model: count words seen with line_valid_o, compare on the report pulse
    always @(negedge clk_i) begin
        if (reset_i) begin
            tb_cnt = 0; pending = 0; prev_lv = 1'b0;
        end else begin
            if (line_stats_valid_o) check_int("line_words", int'(line_words_o), pending);
            if (prev_lv && !line_valid_o) begin
                pending = tb_cnt;
                tb_cnt  = 0;
            end else if (output_valid_o && line_valid_o && tb_cnt < 65535) begin
                tb_cnt++;
            end
            prev_lv = line_valid_o;
        end
    end
`endif

    initial begin
        reset_i      = 1'b1;
        line_valid_i = 1'b0;
        data_valid_i = 1'b0;
        data_i       = 192'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_int("reset_output_valid", int'(output_valid_o), 0);
        check_int("reset_line_valid", int'(line_valid_o), 0);
        check64("reset_output", output_o, 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Directed colour words
        drive(1'b1, 1'b1, {4{px(16'h3FF, 16'h3FF, 16'h3FF)}}, 1'b1, 64'hEB80EB80EB80EB80);
        drive(1'b1, 1'b1, 192'd0, 1'b1, 64'h1080108010801080);
        drive(1'b1, 1'b1, {px(16'h3FF, 16'h0, 16'h0), px(16'h0, 16'h0, 16'h0),
                           px(16'h3FF, 16'h0, 16'h0), px(16'h3FF, 16'h0, 16'h0)},
              1'b1, 64'h526D10B8525A52F0);
        // Valid gap pattern 1,0,1,1 then line end
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b0, 1'b1);
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b0, 1'b0);
        drive_rand(1'b0, 1'b0);

        // Randomized lines with gaps; data valid sometimes outside the line
        for (int i = 0; i < 400; i++) begin
            drive_rand($urandom_range(0, 3) != 0, (i % 60) < 45);
        end
        drive_rand(1'b0, 1'b0);

        // Reset with three words in flight
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b1, 1'b1);
        drive_rand(1'b0, 1'b1);
        #2;
        reset_i      = 1'b1;
        data_valid_i = 1'b0;
        line_valid_i = 1'b0;
        #1;
        check_int("reset_mid_valid", int'(output_valid_o), 0);
        check_int("reset_mid_line", int'(line_valid_o), 0);
        sb.delete();
        last_word = 64'd0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int i = 0; i < 6; i++) drive_rand(1'b0, 1'b0);

`ifdef RGB2YUV_LINE_STATS_EN
        for (int i = 0; i < 820; i++) drive_rand(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) drive_rand(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive_rand(i % 2 == 0, 1'b1);
`endif

        for (int i = 0; i < 40; i++) drive_rand($urandom_range(0, 1) == 1, i < 30);
        for (int i = 0; i < 6; i++) drive_rand(1'b0, 1'b0);
        check_int("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
